// File: rtl/attn_tile_scheduler_if.sv
// Job / scratchpad / PE-array bundle for attn_tile_scheduler.
//   job_*  : descriptor handshake (valid/ready), source/dest base, tile count
//   mem_*  : 16-bit scratchpad read port (1-cycle latency) and write port
//   pe_*   : PE-array run request, 512-bit operands, 256-bit result, done flag
// Modports: master = scheduler side, slave = environment (host, memory, PE array).
interface attn_tile_scheduler_if #(
  parameter int ADDR_W = 12
);
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_src;
  logic [ADDR_W-1:0] job_dst;
  logic [7:0]        job_ntiles;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [15:0]       mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [15:0]       mem_wr_data;

  logic              pe_en;
  logic [511:0]      pe_key;
  logic [511:0]      pe_query;
  logic [511:0]      pe_value;
  logic [255:0]      pe_final_res;
  logic              pe_all_done;

  modport master (
    input  job_valid, job_src, job_dst, job_ntiles,
    output job_ready,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output pe_en, pe_key, pe_query, pe_value,
    input  pe_final_res, pe_all_done
  );

  modport slave (
    output job_valid, job_src, job_dst, job_ntiles,
    input  job_ready,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  pe_en, pe_key, pe_query, pe_value,
    output pe_final_res, pe_all_done
  );
endinterface

// File: rtl/attn_tile_scheduler.sv
// Tile scheduler for the pe_8x8_top attention datapath.
// Per tile: reads 96 scratchpad words into key/query/value operand registers,
// runs the PE array until pe_all_done (or the watchdog expires), then writes
// the 16-word result back. Repeats for job_ntiles tiles.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : attn_tile_scheduler_if.master (job, scratchpad, PE signals)
//   busy        : high in every state except IDLE
//   job_done    : one-cycle pulse at job completion or abort
//   err_timeout : sticky watchdog flag, cleared on the next job accept
module attn_tile_scheduler #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  attn_tile_scheduler_if.master bus,
  output logic                  busy,
  output logic                  job_done,
  output logic                  err_timeout
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W = (RUN_W > 7) ? RUN_W : 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STORE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        tile_q, tile_d;
  logic [7:0]        ntiles_q, ntiles_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [511:0]      key_q, key_d;
  logic [511:0]      query_q, query_d;
  logic [511:0]      value_q, value_d;
  logic [255:0]      res_q, res_d;
  logic              err_q, err_d;

  logic              rd_en, wr_en, pe_en, ready, done;
  logic [6:0]        k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tile_q    <= '0;
      ntiles_q  <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      key_q     <= '0;
      query_q   <= '0;
      value_q   <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tile_q    <= tile_d;
      ntiles_q  <= ntiles_d;
      rd_base_q <= rd_base_d;
      wr_base_q <= wr_base_d;
      key_q     <= key_d;
      query_q   <= query_d;
      value_q   <= value_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tile_d    = tile_q;
    ntiles_d  = ntiles_q;
    rd_base_d = rd_base_q;
    wr_base_d = wr_base_q;
    key_d     = key_q;
    query_d   = query_q;
    value_d   = value_q;
    res_d     = res_q;
    err_d     = err_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    pe_en     = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    // Word index of the data returned this cycle (read issued last cycle).
    k         = cnt_q[6:0] - 7'd1;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.job_valid) begin
          rd_base_d = bus.job_src;
          wr_base_d = bus.job_dst;
          ntiles_d  = bus.job_ntiles;
          tile_d    = '0;
          err_d     = 1'b0;
          cnt_d     = '0;
          state_d   = (bus.job_ntiles == 8'd0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        // cnt 0..95 issue reads; cnt 1..96 capture word cnt-1.
        rd_en = (cnt_q < CNT_W'(96));
        if (cnt_q != '0) begin
          // The three operand blocks are 32 words each, so the low five bits
          // of k give the slot within whichever block k falls in.
          if (k < 7'd32)
            key_d[{k[4:0], 4'd0} +: 16] = bus.mem_rd_data;
          else if (k < 7'd64)
            query_d[{k[4:0], 4'd0} +: 16] = bus.mem_rd_data;
          else
            value_d[{k[4:0], 4'd0} +: 16] = bus.mem_rd_data;
        end
        if (cnt_q == CNT_W'(96)) begin
          cnt_d   = CNT_W'(1);
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RUN: begin
        pe_en = 1'b1;
        if (bus.pe_all_done) begin
          res_d   = bus.pe_final_res;
          cnt_d   = '0;
          state_d = S_STORE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STORE: begin
        wr_en = 1'b1;
        if (cnt_q == CNT_W'(15)) begin
          cnt_d     = '0;
          tile_d    = tile_q + 8'd1;
          rd_base_d = rd_base_q + ADDR_W'(96);
          wr_base_d = wr_base_q + ADDR_W'(16);
          state_d   = ((tile_q + 8'd1) < ntiles_q) ? S_LOAD : S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.job_ready   = ready;
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_en ? (rd_base_q + ADDR_W'(cnt_q)) : '0;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_addr = wr_en ? (wr_base_q + ADDR_W'(cnt_q[3:0])) : '0;
  assign bus.mem_wr_data = wr_en ? res_q[{cnt_q[3:0], 4'd0} +: 16] : '0;
  assign bus.pe_en       = pe_en;
  assign bus.pe_key      = key_q;
  assign bus.pe_query    = query_q;
  assign bus.pe_value    = value_q;
  assign busy            = (state_q != S_IDLE);
  assign job_done        = done;
  assign err_timeout     = err_q;

endmodule

// File: tb/tb_attn_tile_scheduler.sv
module tb_attn_tile_scheduler;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 255;
  localparam int AMASK   = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, job_done, err_timeout;

  attn_tile_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  attn_tile_scheduler #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .job_done(job_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scratchpad model (read-only contents) ----------------
  logic [15:0] mem [0:4095];
  logic [15:0] pend;
  always @(negedge clk) pend = bus.mem_rd_en ? mem[bus.mem_rd_addr] : 16'($urandom);
  always @(posedge clk) begin #1; bus.mem_rd_data = pend; end

  // ---------------- PE array model ----------------
  int           job_lat [256];   // 0 = never completes
  logic [255:0] job_res [256];
  int pe_tile = 0, pe_cyc = 0, cur_lat = 0;
  always @(negedge clk) begin
    if (bus.pe_en) begin
      pe_cyc++;
      if (pe_cyc == 1) begin
        cur_lat = job_lat[pe_tile];
        bus.pe_final_res = job_res[pe_tile];
        pe_tile++;
      end
      bus.pe_all_done = (cur_lat != 0) && (pe_cyc == cur_lat);
    end else begin
      pe_cyc = 0;
      // spurious done pulses where the scheduler must ignore them
      bus.pe_all_done = (bus.mem_wr_en || bus.job_ready) ? 1'($urandom) : 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [511:0] k, q, v; } ops_t;
  int   rd_q[$];
  int   wr_addr_q[$];
  int   wr_data_q[$];
  ops_t ops_q[$];
  int   run_q[$];
  int   done_delta_q[$];
  bit   done_err_q[$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic prev_pe = 1'b0;
  int run_len = 0, accept_cyc = 0, last_done_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", bus.job_ready, 1);
      chk("rst_outs", {bus.mem_rd_en, bus.mem_wr_en, bus.pe_en, busy, job_done, err_timeout,
                       bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data}, 0);
      chk("rst_ops", bus.pe_key | bus.pe_query | bus.pe_value, 0);
      rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); ops_q.delete();
      run_q.delete(); done_delta_q.delete(); done_err_q.delete();
      prev_pe = 1'b0; run_len = 0;
    end else begin
      chk("rd_wr_excl", bus.mem_rd_en & bus.mem_wr_en, 0);
      chk("ready_vs_busy", bus.job_ready, !busy);
      if (bus.mem_rd_en) begin
        if (rd_q.size() == 0) chk("unexp_rd", bus.mem_rd_en, 0);
        else chk("rd_addr", bus.mem_rd_addr, rd_q.pop_front());
      end
      if (bus.mem_wr_en) begin
        if (wr_addr_q.size() == 0) chk("unexp_wr", bus.mem_wr_en, 0);
        else begin
          chk("wr_addr", bus.mem_wr_addr, wr_addr_q.pop_front());
          chk("wr_data", bus.mem_wr_data, wr_data_q.pop_front());
        end
      end
      if (bus.pe_en && !prev_pe) begin
        if (ops_q.size() == 0) chk("unexp_run", bus.pe_en, 0);
        else begin
          ops_t o;
          o = ops_q.pop_front();
          chk("op_key", bus.pe_key, o.k);
          chk("op_query", bus.pe_query, o.q);
          chk("op_value", bus.pe_value, o.v);
        end
      end
      if (bus.pe_en) run_len++;
      if (!bus.pe_en && prev_pe) begin
        if (run_q.size() == 0) chk("unexp_runlen", run_len, 0);
        else chk("run_len", run_len, run_q.pop_front());
        run_len = 0;
      end
      if (job_done) begin
        if (done_delta_q.size() == 0) chk("unexp_done", job_done, 0);
        else begin
          chk("done_latency", cyc - accept_cyc, done_delta_q.pop_front());
          chk("done_err", err_timeout, done_err_q.pop_front());
        end
        last_done_cyc = cyc;
      end
      if (bus.job_valid && bus.job_ready) accept_cyc = cyc;
      prev_pe = bus.pe_en;
    end
  end

  // ---------------- stimulus ----------------
  // lat: -1 random 1..20 per tile, 0 never done, else fixed; resm: 1 = 0xA000+j pattern
  task automatic issue(input int src, input int dst, input int n, input int lat,
                       input bit resm, input bit hold);
    bit   ok;
    int   delta, base;
    bit   err;
    ops_t o;
    @(posedge clk); #1;
    bus.job_valid  = 1'b1;
    bus.job_src    = ADDR_W'(src);
    bus.job_dst    = ADDR_W'(dst);
    bus.job_ntiles = 8'(n);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.job_ready) begin ok = 1'b1; break; end
    end
    chk("accept_wait", ok, 1);
    if (!ok) begin bus.job_valid = 1'b0; return; end
    for (int t = 0; t < n; t++) begin
      job_lat[t] = (lat < 0) ? int'($urandom_range(1, 20)) : lat;
      for (int j = 0; j < 16; j++)
        job_res[t][j*16 +: 16] = resm ? 16'(16'hA000 + j) : 16'($urandom);
    end
    pe_tile = 0;
    delta = 1;
    err = 1'b0;
    for (int t = 0; t < n; t++) begin
      base = src + t * 96;
      for (int i = 0; i < 96; i++) rd_q.push_back((base + i) & AMASK);
      for (int i = 0; i < 32; i++) begin
        o.k[i*16 +: 16] = mem[(base + i) & AMASK];
        o.q[i*16 +: 16] = mem[(base + 32 + i) & AMASK];
        o.v[i*16 +: 16] = mem[(base + 64 + i) & AMASK];
      end
      ops_q.push_back(o);
      if (job_lat[t] == 0) begin
        run_q.push_back(TIMEOUT);
        delta += 97 + TIMEOUT;
        err = 1'b1;
        break;
      end
      run_q.push_back(job_lat[t]);
      for (int j = 0; j < 16; j++) begin
        wr_addr_q.push_back((dst + t * 16 + j) & AMASK);
        wr_data_q.push_back(int'(job_res[t][j*16 +: 16]));
      end
      delta += 97 + job_lat[t] + 16;
    end
    done_delta_q.push_back(delta);
    done_err_q.push_back(err);
    @(posedge clk); #1;
    if (!hold) bus.job_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy && done_delta_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("idle_wait", ok, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    bus.job_valid = 1'b0; bus.job_src = '0; bus.job_dst = '0; bus.job_ntiles = '0;
    bus.pe_final_res = '0; bus.pe_all_done = 1'b0; bus.mem_rd_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single tile, identity scratchpad, done after 10 RUN cycles
    issue(0, 'h100, 1, 10, 1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.pe_en) begin ok = 1'b1; break; end
    end
    chk("t1_run_seen", ok, 1);
    chk("t1_key0", bus.pe_key[15:0], 16'h0000);
    chk("t1_query0", bus.pe_query[15:0], 16'h0020);
    chk("t1_value31", bus.pe_value[511:496], 16'h005F);
    wait_idle();
    chk("t1_err", err_timeout, 0);

    // zero tiles
    issue('h123, 'h456, 0, -1, 1'b0, 1'b0);
    wait_idle();

    // three tiles
    issue('h40, 'h200, 3, -1, 1'b0, 1'b0);
    wait_idle();

    // watchdog abort on first of two tiles, then error cleared by next accept
    issue('h100, 'h900, 2, 0, 1'b0, 1'b0);
    wait_idle();
    chk("err_sticky", err_timeout, 1);
    repeat (5) @(negedge clk);
    chk("err_still", err_timeout, 1);
    issue('h10, 'h800, 1, -1, 1'b0, 1'b0);
    chk("err_cleared", err_timeout, 0);
    wait_idle();

    // done sampled on the very cycle the watchdog would fire
    issue('h300, 'hA00, 1, TIMEOUT, 1'b0, 1'b0);
    wait_idle();
    chk("lat_max_err", err_timeout, 0);

    // job_valid held high across two descriptors
    issue('h20, 'h400, 1, -1, 1'b0, 1'b1);
    issue('h500, 'h600, 2, -1, 1'b0, 1'b0);
    chk("b2b_accept", accept_cyc, last_done_cyc + 1);
    wait_idle();

    // reset in the middle of LOAD
    issue('h80, 'h700, 2, -1, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", bus.job_ready, 1);
    chk("mid_rst_rd", bus.mem_rd_en, 0);
    chk("mid_rst_key", bus.pe_key, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    issue('hF80, 'hFF8, 2, -1, 1'b0, 1'b0);   // both address streams wrap
    wait_idle();

    // randomized jobs over random scratchpad contents
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    for (int r = 0; r < 8; r++) begin
      issue(int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)),
            int'($urandom_range(0, 4)), (r == 5) ? 0 : -1, 1'b0, 1'b0);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_addr_q.size(), 0);
    chk("ops_q_empty", ops_q.size(), 0);
    chk("run_q_empty", run_q.size(), 0);
    chk("done_q_empty", done_delta_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/attn_tile_scheduler.md
Name: attn_tile_scheduler

Overview:
Sequences the pe_8x8_top attention datapath over a batch of tiles held in a shared 16-bit scratchpad. It accepts a job descriptor, streams key/query/value words for each tile into the 512-bit operand registers, and runs the PE array until all_done. It then writes the 256-bit result back to the scratchpad and repeats for the next tile. A cycle-count watchdog aborts a hung PE run.

Parameters:
ADDR_W, 12, scratchpad word-address width
TIMEOUT, 255, maximum RUN cycles per tile before abort (≥2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job descriptor valid
job_ready  out  1  scheduler can accept a job
job_src  in  ADDR_W  base word address of first tile's operands
job_dst  in  ADDR_W  base word address of first tile's results
job_ntiles  in  8  number of tiles to process (0 allowed)
mem_rd_en  out  1  scratchpad read strobe
mem_rd_addr  out  ADDR_W  read address
mem_rd_data  in  16  read data, valid exactly 1 cycle after mem_rd_en
mem_wr_en  out  1  scratchpad write strobe
mem_wr_addr  out  ADDR_W  write address
mem_wr_data  out  16  write data
pe_en  out  1  PE array enable (run request)
pe_key  out  512  key operand, 32×16-bit
pe_query  out  512  query operand
pe_value  out  512  value operand
pe_final_res  in  256  PE result, 16×16-bit
pe_all_done  in  1  PE completion flag
busy  out  1  high in every state except IDLE
job_done  out  1  one-cycle pulse at job completion or abort
err_timeout  out  1  sticky; set on watchdog abort, cleared when the next job is accepted

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. While rst_n is low, all state and registers clear. FSM=IDLE; job_ready=1; every other output, including the operand buses, is 0. Reset mid-job abandons the job; pending reads and writes are dropped and no job_done pulse is issued.
- States: IDLE, LOAD, RUN, STORE, DONE.
- IDLE: job_ready=1. When job_valid&job_ready, latch src/dst/ntiles, clear err_timeout, set tile=0.
  - ntiles=0 → DONE.
  - Otherwise → LOAD.
- LOAD: mem_rd_en=1 for 96 consecutive cycles at addresses src+tile*96+k, k=0..95.
  - Returned word k (1 cycle later) is stored as follows:
    - k<32 → pe_key[k*16+:16]
    - k<64 → pe_query[(k-32)*16+:16]
    - otherwise → pe_value[(k-64)*16+:16]
  - After the last capture (cycle 97 of LOAD) → RUN.
  - pe_en=0 throughout LOAD.
- RUN: pe_en=1 from the first RUN cycle. The cycle counter starts at 1 and increments each cycle.
  - If pe_all_done is sampled high: capture pe_final_res into the result register, drop pe_en → STORE.
  - Else if counter==TIMEOUT: set err_timeout, drop pe_en → DONE. Remaining tiles are skipped and nothing is written.
  - pe_all_done is ignored in every state except RUN.
- STORE: mem_wr_en=1 for 16 consecutive cycles, mem_wr_addr=dst+tile*16+j, mem_wr_data=result[j*16+:16], j=0..15.
  - Then tile+1. If tile+1 < ntiles → LOAD, else → DONE.
- Between tiles, pe_en is low for at least the 97 LOAD cycles; this guarantees the PE sees a restart.
- DONE: job_done=1 for exactly one cycle → IDLE. job_ready rises on the IDLE cycle.
- job_valid while busy is ignored (job_ready=0). The descriptor is not latched.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is allowed and not flagged.
- pe_key/query/value hold their last loaded values until overwritten or reset.
- Reads and writes never overlap; mem_rd_en and mem_wr_en are never high together.
- Latency, per tile: 97 + R + 16 cycles, where R = RUN cycles up to and including the done sample. Job total = 1 accept + Σtiles + 1 DONE.

Test Plan:
- Single tile, src=0, dst=0x100. Scratchpad word i = i. The PE model asserts all_done 10 cycles into RUN with res word j = 0xA000+j. Required response:
  - pe_key[15:0]=0, pe_query[15:0]=0x20, pe_value[511:496]=0x5F.
  - 16 writes 0x100..0x10F with data 0xA000..0xA00F.
  - job_done pulses at cycle 1+97+10+16+1; err_timeout=0.
- ntiles=0 → no mem_rd_en/mem_wr_en/pe_en activity; job_done two cycles after accept.
- ntiles=3, src=0x40, dst=0x200 → read bursts start at 0x40, 0xA0, 0x100; writes at 0x200, 0x210, 0x220; pe_en low between the three RUN windows; a single job_done.
- The PE never asserts all_done, ntiles=2 → pe_en high exactly 255 cycles; err_timeout=1; no writes; job_done pulses. A following job clears err_timeout on accept.
- job_valid held high continuously with two different descriptors → second accepted only after the first job_done; job_ready low the whole time busy=1.
- rst_n asserted at LOAD cycle 40, released 3 cycles later → all outputs 0 immediately; FSM IDLE; no job_done; a new job then completes normally.
